jt10_adpcm_rom_arb: RTL and testbench
=====================================

JT10_ADPCM_ROM_ARB -- requirements
Module: jt10_adpcm_rom_arb

Interface
REQ-001 Parameter A_BASE, default 24'h000000, added to ADPCM-A byte addresses to form the memory address.
REQ-002 Parameter B_BASE, default 24'h400000, added to ADPCM-B byte addresses to form the memory address.
REQ-003 clk  in  1  single clock; all logic runs on its rising edge, full rate with no cen gating.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 adpcma_addr  in  20  ADPCM-A byte address.
REQ-006 adpcma_bank  in  4  ADPCM-A bank; the request address is {bank,addr}, 24 bits.
REQ-007 adpcma_roe_n  in  1  ADPCM-A read enable, active low.
REQ-008 adpcma_data  out  8  byte held for the ADPCM-A requester.
REQ-009 adpcma_ok  out  1  adpcma_data is valid for the current A request address.
REQ-010 adpcmb_addr  in  24  ADPCM-B byte address.
REQ-011 adpcmb_roe_n  in  1  ADPCM-B read enable, active low.
REQ-012 adpcmb_data  out  8  byte held for the ADPCM-B requester.
REQ-013 adpcmb_ok  out  1  adpcmb_data is valid for the current B request address.
REQ-014 mem_addr  out  24  shared ROM byte address.
REQ-015 mem_rd  out  1  shared ROM read strobe, level signal held until acknowledged.
REQ-016 mem_data  in  8  ROM data, sampled only in the cycle mem_ok is high.
REQ-017 mem_ok  in  1  one-cycle ROM acknowledge.

Function
REQ-018 Each channel x SHALL keep a cache: valid bit, 24-bit tag and 8-bit data.
REQ-019 Channel x SHALL be pending when roe_n_x=0 and (cache invalid or tag != current request address), evaluated combinationally every cycle.
REQ-020 The FSM SHALL have three states: IDLE, RD_A, RD_B.
REQ-021 IDLE with exactly one channel pending -> RD_x next cycle; mem_rd=1 and mem_addr=request_x+BASE_x are registered on that same edge.
REQ-022 IDLE with both channels pending -> the channel not served last is granted (round-robin); after reset A is granted first.
REQ-023 RD_x SHALL hold mem_rd=1 and mem_addr stable until mem_ok=1.
REQ-024 On mem_ok in RD_x: cache_x data<=mem_data, tag<=latched address, valid<=1; mem_rd<=0; state<=IDLE; last-served<=x.
REQ-025 Back-to-back grants SHALL have mem_rd low for at least one cycle between reads; one request costs a minimum of 3 cycles (detect, strobe, ok).
REQ-026 mem_addr SHALL be the modulo-2^24 sum; a carry out is discarded (wrap-around).
REQ-027 The in-flight request address SHALL be latched at grant; address changes during RD_x SHALL NOT alter mem_addr.
REQ-028 If the address changes during RD_x, the returned byte SHALL still be cached under the latched tag, ok_x stays 0, and channel x becomes pending again in IDLE.
REQ-029 adpcmx_ok SHALL be high when cache valid and tag == current request address, regardless of roe_n; adpcmx_data = cache data.
REQ-030 roe_n_x=1 SHALL never create a new request; an in-flight read SHALL still complete.
REQ-031 mem_ok received in IDLE SHALL be ignored.

Reset
REQ-032 While rst=1, on each edge: state=IDLE, mem_rd=0, mem_addr=0, both valid bits=0, tags=0, data=0, last-served=B.
REQ-033 Outputs during and after reset: adpcma_data=0, adpcmb_data=0, adpcma_ok=0, adpcmb_ok=0.
REQ-034 Reset asserted mid-read SHALL abort the read; mem_rd SHALL be 0 after the first reset edge, and a late mem_ok SHALL be ignored per REQ-031.

Verification
REQ-035 A only: bank=2, addr=20'h00010, roe_n=0, mem_ok returned 2 cycles after mem_rd with data 8'h5A -> mem_addr=24'h200010, one read, then adpcma_data=8'h5A and adpcma_ok=1; no further mem_rd while the address is held.
REQ-036 A and B pending in the same cycle after reset -> A is granted first, then B; in the next collision B is granted first.
REQ-037 B request with adpcmb_addr=24'hC00001 and B_BASE=24'h400000 -> mem_addr=24'h000001 (wrap).
REQ-038 A address changes from 0x10 to 0x11 during RD_A -> mem_addr stays 0x10, adpcma_ok=0, and a second read at 0x11 follows.
REQ-039 rst pulsed while mem_rd=1 -> mem_rd=0 the next cycle, both ok flags=0, and mem_ok arriving afterwards changes nothing.

Source files
------------

// File: rtl/jt10_adpcm_rom_arb.sv
// Shared ROM arbiter for the ADPCM-A and ADPCM-B readers.
// Each reader keeps a one-byte cache; misses are fetched round-robin.
module jt10_adpcm_rom_arb #(
  parameter logic [23:0] A_BASE = 24'h000000,
  parameter logic [23:0] B_BASE = 24'h400000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] adpcma_addr,
  input  logic [3:0]  adpcma_bank,
  input  logic        adpcma_roe_n,
  output logic [7:0]  adpcma_data,
  output logic        adpcma_ok,
  input  logic [23:0] adpcmb_addr,
  input  logic        adpcmb_roe_n,
  output logic [7:0]  adpcmb_data,
  output logic        adpcmb_ok,
  output logic [23:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  input  logic        mem_ok
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_A = 2'd1,
    RD_B = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [23:0] req_a, req_b;
  logic [23:0] lat, lat_nx;
  logic [23:0] addr_nx;
  logic        rd_nx;
  logic        last_b, last_nx;

  logic        val_a, val_b;
  logic [23:0] tag_a, tag_b;
  logic [7:0]  dat_a, dat_b;

  logic hit_a, hit_b;
  logic pend_a, pend_b;
  logic grant_a, grant_b;
  logic fill_a, fill_b;

  assign req_a = {adpcma_bank, adpcma_addr};
  assign req_b = adpcmb_addr;

  assign hit_a = val_a && (tag_a == req_a);
  assign hit_b = val_b && (tag_b == req_b);

  assign pend_a = !adpcma_roe_n && !hit_a;
  assign pend_b = !adpcmb_roe_n && !hit_b;

  // On a collision, the channel not served last wins
  assign grant_a = pend_a && (!pend_b || last_b);
  assign grant_b = pend_b && !grant_a;

  assign adpcma_ok   = hit_a;
  assign adpcmb_ok   = hit_b;
  assign adpcma_data = dat_a;
  assign adpcmb_data = dat_b;

  always_comb begin
    state_nx = state;
    rd_nx    = mem_rd;
    addr_nx  = mem_addr;
    lat_nx   = lat;
    last_nx  = last_b;
    fill_a   = 1'b0;
    fill_b   = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_a) begin
          state_nx = RD_A;
          rd_nx    = 1'b1;
          addr_nx  = req_a + A_BASE;
          lat_nx   = req_a;
        end else if (grant_b) begin
          state_nx = RD_B;
          rd_nx    = 1'b1;
          addr_nx  = req_b + B_BASE;
          lat_nx   = req_b;
        end
      end
      RD_A: begin
        if (mem_ok) begin
          fill_a   = 1'b1;
          rd_nx    = 1'b0;
          state_nx = IDLE;
          last_nx  = 1'b0;
        end
      end
      RD_B: begin
        if (mem_ok) begin
          fill_b   = 1'b1;
          rd_nx    = 1'b0;
          state_nx = IDLE;
          last_nx  = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        rd_nx    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mem_rd   <= 1'b0;
      mem_addr <= 24'd0;
      lat      <= 24'd0;
      last_b   <= 1'b1;
    end else begin
      state    <= state_nx;
      mem_rd   <= rd_nx;
      mem_addr <= addr_nx;
      lat      <= lat_nx;
      last_b   <= last_nx;
    end
  end

  // Fills use the latched tag, not the live request address
  always_ff @(posedge clk) begin
    if (rst) begin
      val_a <= 1'b0;
      tag_a <= 24'd0;
      dat_a <= 8'd0;
      val_b <= 1'b0;
      tag_b <= 24'd0;
      dat_b <= 8'd0;
    end else begin
      if (fill_a) begin
        val_a <= 1'b1;
        tag_a <= lat;
        dat_a <= mem_data;
      end
      if (fill_b) begin
        val_b <= 1'b1;
        tag_b <= lat;
        dat_b <= mem_data;
      end
    end
  end

endmodule

// File: tb/tb_jt10_adpcm_rom_arb.sv
// Directed bench for jt10_adpcm_rom_arb.
// Inputs change 1ns after a rising edge; outputs checked before the next.
module tb_jt10_adpcm_rom_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] adpcma_addr;
  logic [3:0]  adpcma_bank;
  logic        adpcma_roe_n;
  logic [7:0]  adpcma_data;
  logic        adpcma_ok;
  logic [23:0] adpcmb_addr;
  logic        adpcmb_roe_n;
  logic [7:0]  adpcmb_data;
  logic        adpcmb_ok;
  logic [23:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        mem_ok;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jt10_adpcm_rom_arb dut (
    .clk          (clk),
    .rst          (rst),
    .adpcma_addr  (adpcma_addr),
    .adpcma_bank  (adpcma_bank),
    .adpcma_roe_n (adpcma_roe_n),
    .adpcma_data  (adpcma_data),
    .adpcma_ok    (adpcma_ok),
    .adpcmb_addr  (adpcmb_addr),
    .adpcmb_roe_n (adpcmb_roe_n),
    .adpcmb_data  (adpcmb_data),
    .adpcmb_ok    (adpcmb_ok),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_data     (mem_data),
    .mem_ok       (mem_ok)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single-cycle ROM acknowledge carrying byte d
  task automatic ack(input logic [7:0] d);
    mem_ok   = 1'b1;
    mem_data = d;
    tick();
    mem_ok   = 1'b0;
    mem_data = 8'h00;
  endtask

  initial begin
    rst          = 1'b1;
    adpcma_addr  = 20'h0;
    adpcma_bank  = 4'h0;
    adpcma_roe_n = 1'b1;
    adpcmb_addr  = 24'h0;
    adpcmb_roe_n = 1'b1;
    mem_data     = 8'h00;
    mem_ok       = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_rd", mem_rd, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_ok_a", adpcma_ok, 0);
    chk("rst_ok_b", adpcmb_ok, 0);
    chk("rst_dat_a", adpcma_data, 0);
    chk("rst_dat_b", adpcmb_data, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_rd", mem_rd, 0);

    // collision after reset: A first, then B
    adpcma_bank  = 4'h1;
    adpcma_addr  = 20'h00020;
    adpcma_roe_n = 1'b0;
    adpcmb_addr  = 24'h000100;
    adpcmb_roe_n = 1'b0;
    tick();
    chk("c1_rd", mem_rd, 1);
    chk("c1_addr_a", mem_addr, 24'h100020);
    ack(8'h11);
    chk("c1_gap_rd", mem_rd, 0);
    chk("c1_ok_a", adpcma_ok, 1);
    chk("c1_dat_a", adpcma_data, 8'h11);
    chk("c1_ok_b_lo", adpcmb_ok, 0);
    tick();
    chk("c1_rd_b", mem_rd, 1);
    chk("c1_addr_b", mem_addr, 24'h400100);
    ack(8'h22);
    chk("c1_ok_b", adpcmb_ok, 1);
    chk("c1_dat_b", adpcmb_data, 8'h22);
    chk("c1_end_rd", mem_rd, 0);

    // A-only read, ack two cycles after strobe
    adpcma_bank = 4'h2;
    adpcma_addr = 20'h00010;
    #1;
    chk("a_miss", adpcma_ok, 0);
    tick();
    chk("a_rd", mem_rd, 1);
    chk("a_addr", mem_addr, 24'h200010);
    tick();
    chk("a_rd_hold", mem_rd, 1);
    chk("a_addr_hold", mem_addr, 24'h200010);
    ack(8'h5A);
    chk("a_ok", adpcma_ok, 1);
    chk("a_dat", adpcma_data, 8'h5A);
    chk("a_rd_lo", mem_rd, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("a_no_reread", mem_rd, 0);
    end

    // second collision: A served last, so B first
    adpcma_addr = 20'h00030;
    adpcmb_addr = 24'h000200;
    tick();
    chk("c2_rd_b", mem_rd, 1);
    chk("c2_addr_b", mem_addr, 24'h400200);
    ack(8'h33);
    chk("c2_ok_b", adpcmb_ok, 1);
    chk("c2_dat_b", adpcmb_data, 8'h33);
    chk("c2_ok_a_lo", adpcma_ok, 0);
    tick();
    chk("c2_addr_a", mem_addr, 24'h200030);
    chk("c2_rd_a", mem_rd, 1);
    ack(8'h44);
    chk("c2_ok_a", adpcma_ok, 1);
    chk("c2_dat_a", adpcma_data, 8'h44);

    // B address wraps past 2^24
    adpcmb_addr = 24'hC00001;
    tick();
    chk("wrap_addr", mem_addr, 24'h000001);
    chk("wrap_rd", mem_rd, 1);
    ack(8'h55);
    chk("wrap_ok_b", adpcmb_ok, 1);
    chk("wrap_dat_b", adpcmb_data, 8'h55);

    // A address moves while its read is in flight
    adpcma_bank = 4'h0;
    adpcma_addr = 20'h00010;
    tick();
    chk("mv_addr0", mem_addr, 24'h000010);
    adpcma_addr = 20'h00011;
    tick();
    chk("mv_addr_held", mem_addr, 24'h000010);
    chk("mv_rd_held", mem_rd, 1);
    ack(8'h66);
    chk("mv_ok_a_lo", adpcma_ok, 0);
    chk("mv_rd_lo", mem_rd, 0);
    tick();
    chk("mv_rd2", mem_rd, 1);
    chk("mv_addr2", mem_addr, 24'h000011);
    ack(8'h77);
    chk("mv_ok_a", adpcma_ok, 1);
    chk("mv_dat_a", adpcma_data, 8'h77);

    // roe_n high: no new request, ok still reflects the cache
    adpcma_roe_n = 1'b1;
    adpcma_addr  = 20'h00012;
    tick();
    tick();
    chk("roe_no_rd", mem_rd, 0);
    chk("roe_ok_lo", adpcma_ok, 0);
    adpcma_addr = 20'h00011;
    #1;
    chk("roe_ok_hi", adpcma_ok, 1);

    // stray ack while idle is ignored
    ack(8'hFF);
    chk("idle_ack_dat", adpcma_data, 8'h77);
    chk("idle_ack_rd", mem_rd, 0);

    // reset in the middle of a read
    adpcma_roe_n = 1'b0;
    adpcma_addr  = 20'h00013;
    tick();
    chk("mr_rd", mem_rd, 1);
    rst = 1'b1;
    tick();
    chk("mr_rd_lo", mem_rd, 0);
    chk("mr_ok_a", adpcma_ok, 0);
    chk("mr_ok_b", adpcmb_ok, 0);
    adpcma_roe_n = 1'b1;
    adpcmb_roe_n = 1'b1;
    rst = 1'b0;
    ack(8'h88);
    chk("mr_late_rd", mem_rd, 0);
    chk("mr_late_dat", adpcma_data, 8'h00);
    adpcma_addr = 20'h00000;
    #1;
    chk("mr_late_ok", adpcma_ok, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
